// File: rtl/pc_sequencer.sv
// Instruction sequencer: FETCH/DECODE/EXEC/UPDATE loop, 4 cycles per non-ALU instruction, ALU adds wait cycles.
// Stalls in FETCH on instr_valid and in EXEC on alu_done (16-cycle watchdog); HALT is terminal until rst.
module pc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        alu_done,
  input  logic [31:0] incr_pc,
  output logic [31:0] pc,
  output logic        fetch_req,
  output logic [1:0]  counter_selector,
  output logic [2:0]  brtype,
  output logic [15:0] branch_label,
  output logic [25:0] jmp_label,
  output logic        alu_start,
  output logic        pc_update,
  output logic        halted,
  output logic [1:0]  error,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, UPDATE, HALT
  } state_t;

  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [4:0] WD_LIMIT    = 5'd16;

  state_t      state_q, state_d;
  logic        is_alu;
  logic [4:0]  wd_cnt;

  logic [5:0]  opcode;
  logic [1:0]  dec_sel;
  logic [2:0]  dec_br;
  logic        dec_alu, dec_halt, dec_ill;

  logic        dec_en, wd_clr, wd_inc, pc_ld, ret_inc, err_wr;
  logic [1:0]  err_val;

  assign opcode = instr[31:26];

  always_comb begin
    dec_sel  = 2'd0;
    dec_br   = 3'd0;
    dec_alu  = 1'b0;
    dec_halt = 1'b0;
    dec_ill  = 1'b0;
    if (opcode <= 6'h0F) begin
      dec_alu = 1'b1;
    end else if (opcode == 6'h10) begin
      dec_sel = 2'd1;
    end else if (opcode == 6'h11) begin
      dec_sel = 2'd2;
    end else if (opcode >= 6'h18 && opcode <= 6'h1D) begin
      dec_br = opcode[2:0] + 3'd1;
    end else if (opcode == 6'h3F) begin
      dec_halt = 1'b1;
    end else begin
      dec_ill = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    fetch_req = 1'b0;
    alu_start = 1'b0;
    pc_update = 1'b0;
    halted    = 1'b0;
    dec_en    = 1'b0;
    wd_clr    = 1'b0;
    wd_inc    = 1'b0;
    pc_ld     = 1'b0;
    ret_inc   = 1'b0;
    err_wr    = 1'b0;
    err_val   = 2'd0;
    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        fetch_req = 1'b1;
        if (instr_valid) state_d = DECODE;
      end
      DECODE: begin
        dec_en = 1'b1;
        wd_clr = 1'b1;
        if (dec_ill) begin
          state_d = HALT;
          err_wr  = 1'b1;
          err_val = ERR_ILLEGAL;
        end else if (dec_halt) begin
          state_d = HALT;
          ret_inc = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        // wd_cnt==0 marks the entry cycle; alu_done is only honoured after it
        if (!is_alu) begin
          state_d = UPDATE;
        end else if (wd_cnt == 5'd0) begin
          alu_start = 1'b1;
          wd_inc    = 1'b1;
        end else if (alu_done) begin
          state_d = UPDATE;
        end else if (wd_cnt == WD_LIMIT) begin
          state_d = HALT;
          err_wr  = 1'b1;
          err_val = ERR_TIMEOUT;
        end else begin
          wd_inc = 1'b1;
        end
      end
      UPDATE: begin
        pc_update = 1'b1;
        pc_ld     = 1'b1;
        ret_inc   = 1'b1;
        state_d   = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc               <= 32'd0;
      counter_selector <= 2'd0;
      brtype           <= 3'd0;
      branch_label     <= 16'd0;
      jmp_label        <= 26'd0;
      is_alu           <= 1'b0;
      wd_cnt           <= 5'd0;
      error            <= 2'd0;
      retired          <= 16'd0;
    end else begin
      if (dec_en) begin
        counter_selector <= dec_sel;
        brtype           <= dec_br;
        branch_label     <= instr[15:0];
        jmp_label        <= instr[25:0];
        is_alu           <= dec_alu;
      end
      if (wd_clr)      wd_cnt <= 5'd0;
      else if (wd_inc) wd_cnt <= wd_cnt + 5'd1;
      if (pc_ld)   pc      <= incr_pc;
      if (ret_inc) retired <= retired + 16'd1;
      if (err_wr)  error   <= err_val;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for branch/jump decode plus hand sequences for ALU, halt and reset cases.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] instr;
  logic        instr_valid;
  logic        alu_done;
  logic [31:0] incr_pc;
  logic [31:0] pc;
  logic        fetch_req;
  logic [1:0]  counter_selector;
  logic [2:0]  brtype;
  logic [15:0] branch_label;
  logic [25:0] jmp_label;
  logic        alu_start;
  logic        pc_update;
  logic        halted;
  logic [1:0]  error;
  logic [15:0] retired;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .instr_valid(instr_valid),
    .alu_done(alu_done), .incr_pc(incr_pc), .pc(pc), .fetch_req(fetch_req),
    .counter_selector(counter_selector), .brtype(brtype), .branch_label(branch_label),
    .jmp_label(jmp_label), .alu_start(alu_start), .pc_update(pc_update),
    .halted(halted), .error(error), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] incr;
    logic [1:0]  sel;
    logic [2:0]  br;
    logic [15:0] bl;
    logic [25:0] jl;
  } vec_t;

  vec_t        vecs[6];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc;
  logic [15:0] exp_ret;
  int          starts_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"}, pc, 32'd0);
    chk({tag, "_fetch_req"}, {31'd0, fetch_req}, 32'd0);
    chk({tag, "_csel"}, {30'd0, counter_selector}, 32'd0);
    chk({tag, "_brtype"}, {29'd0, brtype}, 32'd0);
    chk({tag, "_blabel"}, {16'd0, branch_label}, 32'd0);
    chk({tag, "_jlabel"}, {6'd0, jmp_label}, 32'd0);
    chk({tag, "_alu_start"}, {31'd0, alu_start}, 32'd0);
    chk({tag, "_pc_update"}, {31'd0, pc_update}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_error"}, {30'd0, error}, 32'd0);
    chk({tag, "_retired"}, {16'd0, retired}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_pc  = 32'd0;
    exp_ret = 16'd0;
  endtask

  // Pulse start from IDLE; returns at the first FETCH cycle.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at a FETCH cycle; returns at the following FETCH cycle.
  task automatic run_vec(input vec_t v, input string tag);
    chk({tag, "_fetch_req_fetch"}, {31'd0, fetch_req}, 32'd1);
    instr = v.instr; instr_valid = 1'b1; incr_pc = v.incr;
    @(negedge clk);
    instr_valid = 1'b0;
    chk({tag, "_fetch_req_decode"}, {31'd0, fetch_req}, 32'd0);
    @(negedge clk);
    chk({tag, "_csel"}, {30'd0, counter_selector}, {30'd0, v.sel});
    chk({tag, "_brtype"}, {29'd0, brtype}, {29'd0, v.br});
    chk({tag, "_blabel"}, {16'd0, branch_label}, {16'd0, v.bl});
    chk({tag, "_jlabel"}, {6'd0, jmp_label}, {6'd0, v.jl});
    chk({tag, "_alu_start_exec"}, {31'd0, alu_start}, 32'd0);
    @(negedge clk);
    chk({tag, "_pc_update"}, {31'd0, pc_update}, 32'd1);
    chk({tag, "_pc_before"}, pc, exp_pc);
    @(negedge clk);
    exp_pc  = v.incr;
    exp_ret = exp_ret + 16'd1;
    chk({tag, "_pc_after"}, pc, exp_pc);
    chk({tag, "_retired"}, {16'd0, retired}, {16'd0, exp_ret});
    chk({tag, "_pc_update_off"}, {31'd0, pc_update}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h40000000, 32'h00000058, 2'd1, 3'd0, 16'h0000, 26'h0000000};
    vecs[1] = '{32'h60000047, 32'h00000100, 2'd0, 3'd1, 16'h0047, 26'h0000047};
    vecs[2] = '{32'h44001234, 32'h00000200, 2'd2, 3'd0, 16'h1234, 26'h0001234};
    vecs[3] = '{32'h7400ABCD, 32'h00000204, 2'd0, 3'd6, 16'hABCD, 26'h000ABCD};
    vecs[4] = '{32'h68FFFFFF, 32'hDEADBEEC, 2'd0, 3'd3, 16'hFFFF, 26'h0FFFFFF};
    vecs[5] = '{32'h43FFFFFF, 32'h00001000, 2'd1, 3'd0, 16'hFFFF, 26'h3FFFFFF};

    rst = 1'b1; start = 1'b0; instr = 32'd0; instr_valid = 1'b0;
    alu_done = 1'b0; incr_pc = 32'd0; exp_pc = 32'd0; exp_ret = 16'd0;
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // IDLE must ignore instr_valid and hold until start
    instr = 32'h40000000; instr_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold_fetch_req", {31'd0, fetch_req}, 32'd0);
    chk("idle_hold_retired", {16'd0, retired}, 32'd0);
    instr_valid = 1'b0;

    do_start();
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // ALU op 0x05, alu_done glitch on the launch cycle, real done 3 cycles later
    instr = 32'h140000FF; instr_valid = 1'b1; incr_pc = 32'h00002000;
    starts_seen = 0;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("alu_start_entry", {31'd0, alu_start}, 32'd1);
    chk("alu_csel", {30'd0, counter_selector}, 32'd0);
    chk("alu_brtype", {29'd0, brtype}, 32'd0);
    starts_seen += int'(alu_start);
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    chk("alu_done_ignored", {31'd0, pc_update}, 32'd0);
    starts_seen += int'(alu_start);
    @(negedge clk);
    starts_seen += int'(alu_start);
    @(negedge clk);
    starts_seen += int'(alu_start);
    chk("alu_wait_no_update", {31'd0, pc_update}, 32'd0);
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    starts_seen += int'(alu_start);
    chk("alu_update_cycle7", {31'd0, pc_update}, 32'd1);
    chk("alu_start_count", starts_seen, 32'd1);
    @(negedge clk);
    exp_pc = 32'h00002000; exp_ret = exp_ret + 16'd1;
    chk("alu_pc", pc, exp_pc);
    chk("alu_retired", {16'd0, retired}, {16'd0, exp_ret});
    chk("alu_back_in_fetch", {31'd0, fetch_req}, 32'd1);

    // ALU watchdog: alu_done never arrives
    instr = 32'h08000000; instr_valid = 1'b1; incr_pc = 32'h0000BEEF;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("wd_alu_start", {31'd0, alu_start}, 32'd1);
    repeat (16) @(negedge clk);
    chk("wd_not_yet_halted", {31'd0, halted}, 32'd0);
    chk("wd_no_error_yet", {30'd0, error}, 32'd0);
    @(negedge clk);
    chk("wd_halted", {31'd0, halted}, 32'd1);
    chk("wd_error", {30'd0, error}, 32'd2);
    chk("wd_pc", pc, exp_pc);
    chk("wd_retired", {16'd0, retired}, {16'd0, exp_ret});
    start = 1'b1; alu_done = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0; alu_done = 1'b0;
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    chk("halt_no_fetch", {31'd0, fetch_req}, 32'd0);
    chk("halt_error_sticky", {30'd0, error}, 32'd2);

    // Illegal opcode 0x14
    do_reset();
    do_start();
    instr = 32'h50000000; instr_valid = 1'b1; incr_pc = 32'h00000ABC;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("ill_not_halted_decode", {31'd0, halted}, 32'd0);
    @(negedge clk);
    chk("ill_halted", {31'd0, halted}, 32'd1);
    chk("ill_error", {30'd0, error}, 32'd1);
    chk("ill_retired", {16'd0, retired}, 32'd0);
    chk("ill_pc", pc, 32'd0);

    // HALT instruction 0x3F after one jump
    do_reset();
    do_start();
    run_vec(vecs[0], "pre_halt");
    instr = 32'hFC000000; instr_valid = 1'b1; incr_pc = 32'h00000999;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("hlt_halted", {31'd0, halted}, 32'd1);
    chk("hlt_error", {30'd0, error}, 32'd0);
    chk("hlt_retired", {16'd0, retired}, 32'd2);
    chk("hlt_pc", pc, 32'h00000058);

    // Asynchronous reset during ALU EXEC
    do_reset();
    do_start();
    run_vec(vecs[1], "pre_rst");
    instr = 32'h3C00FFFF; instr_valid = 1'b1; incr_pc = 32'h00007777;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("rst_exec_alu_start", {31'd0, alu_start}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'd0; exp_ret = 16'd0;
    @(negedge clk);
    chk("post_rst_idle", {31'd0, fetch_req}, 32'd0);
    do_start();
    chk("restart_pc0", pc, 32'd0);
    run_vec(vecs[2], "restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, leave IDLE and begin fetching at current pc.
REQ-004 SHALL have port instr, input, 32, instruction word; opcode is instr[31:26].
REQ-005 SHALL have port instr_valid, input, 1, instr is valid this cycle.
REQ-006 SHALL have port alu_done, input, 1, ALU finished the started operation.
REQ-007 SHALL have port incr_pc, input, 32, next-PC result from branch_control.
REQ-008 SHALL have port pc, output, 32, architectural program counter, also the instruction fetch address.
REQ-009 SHALL have port fetch_req, output, 1, instruction fetch request.
REQ-010 SHALL have port counter_selector, output, 2, next-PC source select to branch_control.
REQ-011 SHALL have port brtype, output, 3, branch condition select to branch_control.
REQ-012 SHALL have port branch_label, output, 16, instr[15:0] of the current instruction.
REQ-013 SHALL have port jmp_label, output, 26, instr[25:0] of the current instruction.
REQ-014 SHALL have port alu_start, output, 1, one-cycle ALU launch pulse.
REQ-015 SHALL have port pc_update, output, 1, one-cycle pulse when pc is loaded from incr_pc.
REQ-016 SHALL have port halted, output, 1, high while in HALT.
REQ-017 SHALL have port error, output, 2, 0 none, 1 illegal opcode, 2 ALU timeout; sticky until reset.
REQ-018 SHALL have port retired, output, 16, count of completed instructions, wraps 0xFFFF->0.

Function
REQ-019 SHALL implement states IDLE, FETCH, DECODE, EXEC, UPDATE, HALT.
REQ-020 SHALL go from IDLE to FETCH on start=1; start in any other state is ignored.
REQ-021 SHALL, in FETCH, hold fetch_req=1 and go to DECODE on the edge sampling instr_valid=1; instr_valid outside FETCH is ignored.
REQ-022 SHALL, in DECODE, register branch_label, jmp_label, counter_selector and brtype from instr, holding them until the next DECODE.
REQ-023 SHALL decode opcode 0x00-0x0F as ALU: counter_selector=0, brtype=0.
REQ-024 SHALL decode opcode 0x10 as jump: counter_selector=1, brtype=0.
REQ-025 SHALL decode opcode 0x11 as jump-register: counter_selector=2, brtype=0.
REQ-026 SHALL decode opcodes 0x18-0x1D as conditional branches: counter_selector=0, brtype=opcode[2:0]+1, giving 1..6.
REQ-027 SHALL decode opcode 0x3F as HALT instruction: DECODE->HALT, error unchanged, pc unchanged, retired incremented.
REQ-028 SHALL treat every other opcode as illegal: DECODE->HALT, error=1, pc unchanged, retired unchanged.
REQ-029 SHALL, in EXEC for ALU class, pulse alu_start on the entry cycle only and wait for alu_done.
REQ-030 SHALL only sample alu_done from the cycle after alu_start onward.
REQ-031 SHALL enforce an ALU watchdog: if alu_done is not seen within 16 cycles after alu_start, go to HALT with error=2.
REQ-032 SHALL spend exactly one cycle in EXEC for non-ALU classes.
REQ-033 SHALL, in UPDATE (one cycle), load pc<=incr_pc, pulse pc_update, increment retired, then go to FETCH.
REQ-034 SHALL complete a non-ALU instruction in a minimum of 4 cycles (FETCH, DECODE, EXEC, UPDATE) when instr_valid is already high in FETCH.
REQ-035 SHALL remain in HALT until reset.

Reset
REQ-036 SHALL, on rst=1 and at any time including mid-instruction, immediately force: state=IDLE, pc=0, fetch_req=0, counter_selector=0, brtype=0, branch_label=0, jmp_label=0, alu_start=0, pc_update=0, halted=0, error=0, retired=0.
REQ-037 SHALL hold IDLE after rst deasserts until start=1.

Verification
REQ-038 Reset then start, instr=0x40000000 (jump, jmp_label 0), incr_pc=0x58 -> fetch_req high 1 cycle, counter_selector=1 in cycle 3, pc=0x58 with pc_update pulse in cycle 4, retired=1.
REQ-039 Branch instr=0x60000047 (opcode 0x18) -> brtype=1, counter_selector=0, branch_label=0x0047; pc loads incr_pc.
REQ-040 ALU instr opcode 0x05, alu_done asserted 3 cycles after alu_start -> exactly one alu_start pulse, UPDATE follows alu_done, total 7 cycles.
REQ-041 ALU instr with alu_done never asserted -> HALT after 16 cycles, error=2, halted=1, pc unchanged.
REQ-042 Opcode 0x14 -> HALT, error=1, retired unchanged; opcode 0x3F -> HALT, error=0, retired+1.
REQ-043 rst asserted during EXEC of an ALU instruction -> all outputs return to reset values in the same cycle; start then restarts from pc=0.
